// File: rtl/tc_bank.sv
// Bank of N_CH independent prescaled down-counters with one-shot/auto-reload
// modes, sticky W1C pending bits and per-channel interrupt masking.
module tc_bank #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PRE_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      addr,
    input  logic            we,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);

    localparam int unsigned CTRL_W = 4;
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESET   = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;
    localparam logic [5:0] ADDR_PEND    = 6'h20;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    state_e             state_q    [N_CH];
    state_e             state_d    [N_CH];
    logic [CTRL_W-1:0]  ctrl_q     [N_CH];
    logic [CTRL_W-1:0]  ctrl_d     [N_CH];
    logic [CNT_W-1:0]   preset_q   [N_CH];
    logic [CNT_W-1:0]   preset_d   [N_CH];
    logic [CNT_W-1:0]   count_q    [N_CH];
    logic [CNT_W-1:0]   count_d    [N_CH];
    logic [PRE_W-1:0]   prescale_q [N_CH];
    logic [PRE_W-1:0]   prescale_d [N_CH];
    logic [PRE_W-1:0]   presc_q    [N_CH];
    logic [PRE_W-1:0]   presc_d    [N_CH];
    logic [N_CH-1:0]    pend_q;
    logic [N_CH-1:0]    pend_d;

    logic [2:0] ch_sel;
    logic [1:0] reg_sel;
    logic       ch_hit;
    logic       pend_hit;
    logic       unused_din;

    assign ch_sel     = addr[4:2];
    assign reg_sel    = addr[1:0];
    assign ch_hit     = !addr[5] && (32'(ch_sel) < N_CH);
    assign pend_hit   = (addr == ADDR_PEND);
    assign unused_din = ^din;

    // Next-state: PEND clear first so an INT set in the same cycle wins;
    // bus CTRL writes last so they override the FSM clearing EN.
    always_comb begin
        pend_d = pend_q;
        if (we && pend_hit) begin
            pend_d = pend_q & ~din[N_CH-1:0];
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i]    = state_q[i];
            ctrl_d[i]     = ctrl_q[i];
            preset_d[i]   = preset_q[i];
            count_d[i]    = count_q[i];
            prescale_d[i] = prescale_q[i];
            presc_d[i]    = presc_q[i];

            case (state_q[i])
                S_IDLE: begin
                    if (ctrl_q[i][0]) begin
                        state_d[i] = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d[i] = preset_q[i];
                    presc_d[i] = prescale_q[i];
                    state_d[i] = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[i][0]) begin
                        state_d[i] = S_IDLE;
                    end else if (presc_q[i] != '0) begin
                        presc_d[i] = presc_q[i] - PRE_ONE;
                    end else begin
                        presc_d[i] = prescale_q[i];
                        if (count_q[i] != '0) begin
                            count_d[i] = count_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = S_INT;
                        end
                    end
                end
                S_INT: begin
                    pend_d[i] = 1'b1;
                    if (ctrl_q[i][2:1] == MODE_RELOAD) begin
                        state_d[i] = S_LOAD;
                    end else begin
                        ctrl_d[i][0] = 1'b0;
                        state_d[i]   = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase

            if (we && ch_hit && (ch_sel == 3'(i))) begin
                case (reg_sel)
                    REG_CTRL:     ctrl_d[i]     = din[CTRL_W-1:0];
                    REG_PRESET:   preset_d[i]   = din[CNT_W-1:0];
                    REG_PRESCALE: prescale_d[i] = din[PRE_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i]    <= S_IDLE;
                ctrl_q[i]     <= '0;
                preset_q[i]   <= '0;
                count_q[i]    <= '0;
                prescale_q[i] <= '0;
                presc_q[i]    <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i]    <= state_d[i];
                ctrl_q[i]     <= ctrl_d[i];
                preset_q[i]   <= preset_d[i];
                count_q[i]    <= count_d[i];
                prescale_q[i] <= prescale_d[i];
                presc_q[i]    <= presc_d[i];
            end
        end
    end

    // Zero-extended read mux; unmapped addresses fall through to 0.
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_hit && (ch_sel == 3'(i))) begin
                case (reg_sel)
                    REG_CTRL:     dout = 32'(ctrl_q[i]);
                    REG_PRESET:   dout = 32'(preset_q[i]);
                    REG_COUNT:    dout = 32'(count_q[i]);
                    REG_PRESCALE: dout = 32'(prescale_q[i]);
                    default:      dout = '0;
                endcase
            end
        end
        if (pend_hit) begin
            dout = 32'(pend_q);
        end
    end

    always_comb begin
        irq = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            irq[i] = pend_q[i] & ctrl_q[i][3];
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_tc_bank.sv
// Scoreboard bench for tc_bank: a default instance and an N_CH=3/CNT_W=16
// instance share one bus; expectations are queued and popped on observation.
module tb_tc_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] dout3;
    logic [1:0]  irq;
    logic        irq_any;
    logic [2:0]  irq3;
    logic        irq_any3;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int e0, t, tprev;

    string       sb_tag [$];
    logic [31:0] sb_exp [$];

    tc_bank dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
        .dout(dout), .irq(irq), .irq_any(irq_any)
    );

    tc_bank #(.N_CH(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
        .dout(dout3), .irq(irq3), .irq_any(irq_any3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] e);
        sb_tag.push_back(tag);
        sb_exp.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] got);
        check_val(sb_tag.pop_front(), got, sb_exp.pop_front());
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string tag, input bit sel3 = 1'b0);
        push_exp(tag, e);
        addr = a;
        we   = 1'b0;
        #1;
        pop_cmp(sel3 ? dout3 : dout);
    endtask

    task automatic wait_irq(input int b, input int bound, output int tt);
        tt = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (irq[b]) begin
                tt = cyc;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int a = 0; a < 64; a++) begin
            rd(6'(a), 32'h0, "rst_rd");
            rd(6'(a), 32'h0, "rst_rd3", 1'b1);
        end
        push_exp("rst_irq", 32'h0);
        pop_cmp(32'({irq_any3, irq3, irq_any, irq}));

        // ch0 one-shot, P=5 S=0
        wr(6'd1, 32'd5);
        wr(6'd3, 32'd0);
        wr(6'd0, 32'h9);
        e0 = cyc;
        push_exp("ch0_latency", 32'd9);
        wait_irq(0, 50, t);
        pop_cmp(32'(t - e0));
        push_exp("ch0_irq_any", 32'd1);
        pop_cmp(32'(irq_any));
        rd(6'd0, 32'h8, "ch0_ctrl_after");
        rd(6'd2, 32'h0, "ch0_count_after");
        rd(6'h20, 32'h1, "ch0_pend_set");
        wr(6'h20, 32'h1);
        push_exp("ch0_irq_cleared", 32'd0);
        pop_cmp(32'(irq[0]));
        rd(6'h20, 32'h0, "ch0_pend_cleared");
        repeat (20) @(negedge clk);
        push_exp("ch0_oneshot_quiet", 32'd0);
        pop_cmp(32'(irq[0]));

        // ch1 auto-reload, P=3 S=2
        wr(6'd5, 32'd3);
        wr(6'd7, 32'd2);
        wr(6'd4, 32'hB);
        e0 = cyc;
        push_exp("ch1_first_latency", 32'd15);
        wait_irq(1, 100, t);
        pop_cmp(32'(t - e0));
        push_exp("ch1_irq_any", 32'd1);
        pop_cmp(32'(irq_any));
        for (int r = 0; r < 2; r++) begin
            tprev = t;
            wr(6'h20, 32'h2);
            push_exp("ch1_irq_drop", 32'd0);
            pop_cmp(32'(irq[1]));
            push_exp("ch1_period", 32'd14);
            wait_irq(1, 100, t);
            pop_cmp(32'(t - tprev));
            push_exp("ch1_irq_any_period", 32'd1);
            pop_cmp(32'(irq_any));
        end

        // PEND clear issued in the INT cycle: set wins
        tprev = t;
        wr(6'h20, 32'h2);
        while (cyc < tprev + 13) @(negedge clk);
        push_exp("ch1_pre_int_low", 32'd0);
        pop_cmp(32'(irq[1]));
        addr = 6'h20;
        din  = 32'h2;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        push_exp("ch1_set_wins_irq", 32'd1);
        pop_cmp(32'(irq[1]));
        rd(6'h20, 32'h2, "ch1_set_wins_pend");

        // IM=0: pend sets, irq stays low
        wr(6'd4, 32'h0);
        repeat (20) @(negedge clk);
        wr(6'h20, 32'h3);
        rd(6'h20, 32'h0, "im0_pend_start");
        wr(6'd4, 32'h3);
        e0 = cyc;
        while (cyc < e0 + 14) @(negedge clk);
        rd(6'h20, 32'h0, "im0_pend_before");
        @(negedge clk);
        rd(6'h20, 32'h2, "im0_pend_after");
        push_exp("im0_irq_low", 32'd0);
        pop_cmp(32'(irq[1]));
        push_exp("im0_irq_any_low", 32'd0);
        pop_cmp(32'(irq_any));
        wr(6'd4, 32'h0);
        repeat (20) @(negedge clk);
        wr(6'h20, 32'h3);

        // ch0 software disable mid-count, then re-enable
        wr(6'd1, 32'd100);
        wr(6'd3, 32'd3);
        wr(6'd0, 32'h1);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            addr = 6'd2;
            #1;
            if (dout == 32'd40) break;
        end
        wr(6'd0, 32'h0);
        repeat (200) @(negedge clk);
        rd(6'd2, 32'd40, "hold_count");
        rd(6'h20, 32'h0, "hold_no_pend");
        wr(6'd0, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rd(6'd2, 32'd100, "reload_count");
        wr(6'd0, 32'h0);

        // Narrow instance and unmapped space
        wr(6'd9, 32'h1234ABCD);
        rd(6'd9, 32'h0000ABCD, "n3_preset_trunc", 1'b1);
        rd(6'd9, 32'h0, "n2_ch2_unmapped");
        wr(6'd17, 32'h55);
        rd(6'd17, 32'h0, "n3_ch4_unmapped", 1'b1);
        wr(6'h21, 32'hFF);
        rd(6'h21, 32'h0, "n3_glob1_unmapped", 1'b1);
        rd(6'h21, 32'h0, "n2_glob1_unmapped");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_bank.md
# tc_bank

Parametrised timer/counter bank for the P7 MIPS system. It replaces the pair of fixed single-channel timers behind the Bridge with one block of `N_CH` independent down-counters. Each channel has a programmable prescaler, one-shot or auto-reload mode, and a sticky, write-1-to-clear pending bit. Per-channel interrupt lines feed `HWInt`, and `irq_any` feeds a single interrupt input.

## Interface
- `N_CH`, 2, number of channels (1..8)
- `CNT_W`, 32, counter/PRESET width (8..32)
- `PRE_W`, 8, prescaler width (1..16)

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  6  word address (Bridge byte address [7:2])
  - `addr[5]=0`: channel space, with channel `addr[4:2]` and register `addr[1:0]`
  - `addr[5]=1`: global space
- `we`  in  1  write strobe, one write per cycle
- `din`  in  32  write data
- `dout`  out  32  combinational read data of addressed register
- `irq`  out  N_CH  per-channel interrupt, `pend[i] & CTRL[i].IM`
- `irq_any`  out  1  OR of `irq`

## Operation
- Per-channel registers:
  - reg 0, CTRL: `[0]` EN, `[2:1]` MODE, `[3]` IM. Bits above 3 read 0.
  - reg 1, PRESET: `CNT_W` bits.
  - reg 2, COUNT: read-only.
  - reg 3, PRESCALE: `PRE_W` bits.
- Global register word 0, PEND: `N_CH` sticky bits. Writes clear every bit where `din` is 1.
- Reads zero-extend to 32 bits. Unmapped addresses (channel ≥ N_CH, global word ≠ 0) read 0 and ignore writes.
- Writes to COUNT are ignored. PRESET and PRESCALE writes take effect only at the next LOAD.
- MODE 0 is one-shot. MODE 1 is auto-reload. MODEs 2 and 3 behave as MODE 0.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT←PRESET, presc←PRESCALE → CNT.
  - CNT, EN=0: → IDLE, holding COUNT.
  - CNT, EN=1, presc≠0: presc−1.
  - CNT, EN=1, presc=0 (a tick): presc←PRESCALE. If COUNT≠0, COUNT−1. If COUNT=0, → INT.
  - INT: pend[i]←1.
    - MODE 1: → LOAD.
    - Otherwise: EN←0, → IDLE.
- Simultaneous events:
  - PEND clear and INT set of the same bit in one cycle: set wins.
  - CTRL write and INT clearing EN in one cycle: the CTRL write wins.
- EN cleared by software mid-count: no interrupt. Re-enabling reloads from PRESET.
- Channels are fully independent and share only the bus.

## Timing
- Reset: every register, pend, presc and COUNT is 0; all FSMs are in IDLE; `irq`, `irq_any` and `dout` are 0.
- Let E0 be the edge at which a CTRL write sets EN, with PRESET=P and PRESCALE=S.
  - E1: LOAD.
  - E2: COUNT=P, state CNT.
  - pend[i] goes to 1 at edge E0 + (P+1)(S+1) + 3.
  - `irq[i]` follows in the same cycle if IM=1.
- Auto-reload period between successive pend sets: (P+1)(S+1) + 2 cycles.
- Clearing pend via PEND write: `irq` drops on the edge after the write. Reads are combinational, with zero-cycle latency.

## Test plan
- Reset, then read all addresses → all 0; `irq`=0, `irq_any`=0.
- ch0: PRESET=5, PRESCALE=0, then CTRL=0b1001 (EN, MODE0, IM) at E0:
  - `irq[0]` rises after edge E0+9.
  - CTRL reads 0b1000 afterwards and COUNT reads 0.
  - Write PEND=1 → `irq[0]` low next cycle.
- ch1: PRESET=3, PRESCALE=2, CTRL=0b1011 (MODE1):
  - First pend after (4·3)+3 = 15 edges.
  - After each PEND clear, pend re-sets every 14 cycles.
  - `irq_any`=1 whenever `irq[1]`=1.
- ch0 counting with PRESET=100: write CTRL EN=0 when COUNT=40 → COUNT holds 40 and pend never sets. Re-enable → COUNT reloads 100.
- Clear PEND in the exact cycle ch1's FSM is in INT → pend stays 1. With IM=0 → pend sets but `irq` stays 0.
- `N_CH`=3, `CNT_W`=16: PRESET write 0x1234ABCD reads 0xABCD. Channel 4 and global word 1 read 0 and ignore writes.
